// File: rtl/multichannel_wave_synth.sv
// rtl/multichannel_wave_synth.sv - multi-channel phase-accumulator waveform synthesizer
// Per-channel saw/triangle/square/ROM/DC oscillators with shadowed settings committed at wrap.
module multichannel_wave_synth #(
  parameter int CHANNELS = 2,
  parameter int DATA_W   = 8,
  parameter int PHASE_W  = 16,
  parameter int ADDR_W   = 10,
  parameter int AMP_W    = 4
) (
  input  logic                         CLKOSILLATOR,
  input  logic                         RST,
  input  logic                         SYNC,
  input  logic                         CFG_VALID,
  output logic                         CFG_READY,
  input  logic [2:0]                   CFG_CH,
  input  logic [2:0]                   CFG_ADDR,
  input  logic [15:0]                  CFG_DATA,
  output logic [CHANNELS*ADDR_W-1:0]   ROM_ADDR,
  input  logic [CHANNELS*DATA_W-1:0]   ROM_DATA,
  output logic [CHANNELS-1:0]          WRAP,
  output logic [CHANNELS*DATA_W-1:0]   OUTPUTWAVE
);

  localparam logic [3:0] CH_LIM = 4'(CHANNELS);
  localparam int PROD_W = DATA_W + AMP_W + 1;
  localparam logic [DATA_W-1:0] DUTY_RST = {1'b1, {(DATA_W-1){1'b0}}};

  logic rst_q;
  logic wr_ok;

  always_ff @(posedge CLKOSILLATOR) rst_q <= RST;

  // Port stays closed for one extra cycle after reset so the first write lands on settled state.
  assign CFG_READY = !RST && !rst_q && !SYNC;
  assign wr_ok     = CFG_VALID && CFG_READY && (CFG_ADDR < 3'd5) && ({1'b0, CFG_CH} < CH_LIM);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [PHASE_W-1:0] acc, ftw;
    logic [PHASE_W:0]   sum;
    logic               en, carry, sel, commit, wrap_q;
    logic [2:0]         mode, mode_sh, mode_n;
    logic [AMP_W-1:0]   amp, amp_sh, amp_n, amp_q;
    logic [DATA_W-1:0]  off, off_sh, off_n, duty, duty_sh, duty_n;
    logic [DATA_W-1:0]  p, tri_w, raw_c, raw_q, off_q, src, sat, out_q;
    logic               rom_q, en_q;
    logic [AMP_W:0]     amp_inc;
    logic [PROD_W-1:0]  prod, scaled;
    logic [PROD_W:0]    total;

    assign sum    = {1'b0, acc} + {1'b0, ftw};
    assign carry  = en && sum[PHASE_W];
    assign sel    = wr_ok && (CFG_CH == 3'(c));
    // A disabled channel has no wrap to wait for, so its shadows pass straight through.
    assign commit = SYNC || !en || carry;

    always_comb begin
      mode_n = mode_sh;
      amp_n  = amp_sh;
      off_n  = off_sh;
      duty_n = duty_sh;
      if (sel) begin
        case (CFG_ADDR)
          3'd1:    mode_n = CFG_DATA[3:1];
          3'd2:    amp_n  = CFG_DATA[AMP_W-1:0];
          3'd3:    off_n  = CFG_DATA[DATA_W-1:0];
          3'd4:    duty_n = CFG_DATA[DATA_W-1:0];
          default: ;
        endcase
      end
    end

    assign p     = acc[PHASE_W-1 -: DATA_W];
    assign tri_w = p[DATA_W-1] ? ~{p[DATA_W-2:0], 1'b0} : {p[DATA_W-2:0], 1'b0};

    always_comb begin
      raw_c = '1;
      case (mode)
        3'd0:    raw_c = p;
        3'd1:    raw_c = tri_w;
        3'd2:    raw_c = (p < duty) ? '1 : '0;
        default: raw_c = '1;
      endcase
    end

    // Stage 2: ROM data arrives here in step with the registered internal waveform.
    assign src     = rom_q ? ROM_DATA[c*DATA_W +: DATA_W] : raw_q;
    assign amp_inc = {1'b0, amp_q} + (AMP_W+1)'(1);
    assign prod    = PROD_W'(src) * PROD_W'(amp_inc);
    assign scaled  = prod >> AMP_W;
    assign total   = {1'b0, scaled} + (PROD_W+1)'(off_q);
    assign sat     = (total > (PROD_W+1)'({DATA_W{1'b1}})) ? '1 : total[DATA_W-1:0];

    always_ff @(posedge CLKOSILLATOR) begin
      if (RST) begin
        acc     <= '0;
        ftw     <= '0;
        en      <= 1'b0;
        wrap_q  <= 1'b0;
        mode    <= '0;
        mode_sh <= '0;
        amp     <= '1;
        amp_sh  <= '1;
        off     <= '0;
        off_sh  <= '0;
        duty    <= DUTY_RST;
        duty_sh <= DUTY_RST;
        raw_q   <= '0;
        rom_q   <= 1'b0;
        amp_q   <= '1;
        off_q   <= '0;
        en_q    <= 1'b0;
        out_q   <= '0;
      end else begin
        acc    <= SYNC ? '0 : (en ? sum[PHASE_W-1:0] : acc);
        wrap_q <= carry && !SYNC;
        if (sel && CFG_ADDR == 3'd0) ftw <= CFG_DATA[PHASE_W-1:0];
        if (sel && CFG_ADDR == 3'd1) en  <= CFG_DATA[0];
        mode_sh <= mode_n;
        amp_sh  <= amp_n;
        off_sh  <= off_n;
        duty_sh <= duty_n;
        if (commit) begin
          mode <= mode_n;
          amp  <= amp_n;
          off  <= off_n;
          duty <= duty_n;
        end
        // Settings travel with the sample so a wrap-time commit never splits one sample.
        raw_q <= raw_c;
        rom_q <= (mode == 3'd3);
        amp_q <= amp;
        off_q <= off;
        en_q  <= en;
        out_q <= en_q ? sat : '0;
      end
    end

    assign ROM_ADDR[c*ADDR_W +: ADDR_W]   = acc[PHASE_W-1 -: ADDR_W];
    assign WRAP[c]                        = wrap_q;
    assign OUTPUTWAVE[c*DATA_W +: DATA_W] = out_q;
  end

endmodule

// File: tb/tb_multichannel_wave_synth.sv
// tb/tb_multichannel_wave_synth.sv - scoreboard bench for multichannel_wave_synth
// Reference model predicts every sample; a monitor compares after each rising edge.
module tb_multichannel_wave_synth;
  localparam int CH = 2;
  localparam int DW = 8;
  localparam int AW = 10;

  logic              CLKOSILLATOR = 1'b0;
  logic              RST = 1'b1;
  logic              SYNC = 1'b0;
  logic              CFG_VALID = 1'b0;
  logic              CFG_READY;
  logic [2:0]        CFG_CH = '0;
  logic [2:0]        CFG_ADDR = '0;
  logic [15:0]       CFG_DATA = '0;
  logic [CH*AW-1:0]  ROM_ADDR;
  logic [CH*DW-1:0]  ROM_DATA;
  logic [CH-1:0]     WRAP;
  logic [CH*DW-1:0]  OUTPUTWAVE;

  multichannel_wave_synth dut (
    .CLKOSILLATOR(CLKOSILLATOR), .RST(RST), .SYNC(SYNC),
    .CFG_VALID(CFG_VALID), .CFG_READY(CFG_READY), .CFG_CH(CFG_CH),
    .CFG_ADDR(CFG_ADDR), .CFG_DATA(CFG_DATA), .ROM_ADDR(ROM_ADDR),
    .ROM_DATA(ROM_DATA), .WRAP(WRAP), .OUTPUTWAVE(OUTPUTWAVE)
  );

  always #5 CLKOSILLATOR = ~CLKOSILLATOR;

  // External synchronous ROM: data = inverted low byte of the address, one cycle later.
  always @(posedge CLKOSILLATOR)
    for (int c = 0; c < CH; c++) ROM_DATA[c*DW +: DW] <= ~ROM_ADDR[c*AW +: DW];

  typedef struct {
    logic [CH*DW-1:0] wave;
    logic [CH-1:0]    wrap;
    logic [CH*AW-1:0] rom;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int checks = 0;
  int passed = 0;

  int m_acc[CH], m_ftw[CH], m_en[CH];
  int m_mode[CH], m_amp[CH], m_off[CH], m_duty[CH];
  int s_mode[CH], s_amp[CH], s_off[CH], s_duty[CH];
  int m_s1[CH], m_out[CH], m_wrap[CH];
  bit m_rst_prev = 1'b1;

  function automatic int wave_of(input int c);
    int p, raw, v;
    p = m_acc[c] / 256;
    case (m_mode[c])
      0: raw = p;
      1: raw = (p < 128) ? 2 * p : 511 - 2 * p;
      2: raw = (p < m_duty[c]) ? 255 : 0;
      3: raw = 255 - ((m_acc[c] / 64) % 256);
      default: raw = 255;
    endcase
    v = (raw * (m_amp[c] + 1)) / 16 + m_off[c];
    if (v > 255) v = 255;
    return m_en[c] ? v : 0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_acc[c] = 0; m_ftw[c] = 0; m_en[c] = 0;
      m_mode[c] = 0; m_amp[c] = 15; m_off[c] = 0; m_duty[c] = 128;
      s_mode[c] = 0; s_amp[c] = 15; s_off[c] = 0; s_duty[c] = 128;
      m_s1[c] = 0; m_out[c] = 0; m_wrap[c] = 0;
    end
    m_rst_prev = 1'b1;
  endtask

  task automatic model_edge(input bit v, input int ch, input int a, input int d,
                            input bit s, input bit r);
    bit acc_w, carry;
    int nxt;
    exp_t e;
    if (r) begin
      model_reset();
    end else begin
      acc_w = v && !m_rst_prev && !s && ch < CH && a < 5;
      for (int c = 0; c < CH; c++) begin
        m_out[c] = m_s1[c];
        m_s1[c]  = wave_of(c);
        nxt   = m_acc[c] + m_ftw[c];
        carry = (m_en[c] != 0) && nxt >= 65536;
        if (acc_w && ch == c) begin
          if (a == 1) s_mode[c] = (d / 2) % 8;
          if (a == 2) s_amp[c]  = d % 16;
          if (a == 3) s_off[c]  = d % 256;
          if (a == 4) s_duty[c] = d % 256;
        end
        if (s || m_en[c] == 0 || carry) begin
          m_mode[c] = s_mode[c]; m_amp[c] = s_amp[c];
          m_off[c]  = s_off[c];  m_duty[c] = s_duty[c];
        end
        m_acc[c]  = s ? 0 : (m_en[c] != 0 ? nxt % 65536 : m_acc[c]);
        m_wrap[c] = (carry && !s) ? 1 : 0;
        if (acc_w && ch == c) begin
          if (a == 0) m_ftw[c] = d % 65536;
          if (a == 1) m_en[c]  = d % 2;
        end
      end
      m_rst_prev = 1'b0;
    end
    for (int c = 0; c < CH; c++) begin
      e.wave[c*DW +: DW] = DW'(m_out[c]);
      e.wrap[c]          = (m_wrap[c] != 0);
      e.rom[c*AW +: AW]  = AW'(m_acc[c] / 64);
    end
    exp_q.push_back(e);
  endtask

  task automatic step(input bit v, input int ch, input int a, input int d,
                      input bit s, input bit r);
    bit exp_rdy;
    @(negedge CLKOSILLATOR);
    CFG_VALID = v; CFG_CH = 3'(ch); CFG_ADDR = 3'(a); CFG_DATA = 16'(d);
    SYNC = s; RST = r;
    #1;
    exp_rdy = !r && !m_rst_prev && !s;
    checks++;
    if (CFG_READY === exp_rdy) passed++;
    else $display("FAIL cfg_ready t=%0t got %b want %b", $time, CFG_READY, exp_rdy);
    model_edge(v, ch, a, d, s, r);
  endtask

  task automatic wr(input int ch, input int a, input int d);
    step(1'b1, ch, a, d, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, int'($urandom % 8), int'($urandom % 8), int'($urandom % 65536), 1'b0, 1'b0);
  endtask

  always @(posedge CLKOSILLATOR) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (OUTPUTWAVE === mon_e.wave) passed++;
      else $display("FAIL outputwave t=%0t got %h want %h", $time, OUTPUTWAVE, mon_e.wave);
      checks++;
      if (WRAP === mon_e.wrap) passed++;
      else $display("FAIL wrap t=%0t got %b want %b", $time, WRAP, mon_e.wrap);
      checks++;
      if (ROM_ADDR === mon_e.rom) passed++;
      else $display("FAIL rom_addr t=%0t got %h want %h", $time, ROM_ADDR, mon_e.rom);
    end
  end

  initial begin
    int v, ch, a, d;
    model_reset();
    // Reset held with random config traffic that must be ignored.
    for (int i = 0; i < 3; i++)
      step(1'b1, int'($urandom % 2), int'($urandom % 5), int'($urandom % 65536), 1'b0, 1'b1);
    idle(2);
    // Saw on channel 0.
    wr(0, 0, 16'h0100);
    wr(0, 1, 1);
    idle(360);
    // Shadowed amplitude change mid-period.
    wr(0, 2, 7);
    idle(300);
    // DC with offset saturation on channel 1, then square with duty.
    wr(1, 2, 3);
    wr(1, 3, 200);
    wr(1, 1, (4 << 1) | 1);
    idle(10);
    wr(1, 0, 16'h0100);
    wr(1, 2, 15);
    wr(1, 4, 64);
    wr(1, 1, (2 << 1) | 1);
    idle(600);
    // ROM mode on channel 1 beside saw on channel 0.
    wr(1, 1, 0);
    wr(1, 0, 16'h0040);
    wr(1, 2, 15);
    wr(1, 3, 0);
    wr(1, 1, (3 << 1) | 1);
    wr(0, 2, 15);
    idle(300);
    // SYNC with pending shadows, and SYNC colliding with a write.
    wr(0, 0, 16'h0300);
    wr(0, 2, 3);
    wr(1, 1, (1 << 1) | 1);
    step(1'b0, 0, 0, 0, 1'b1, 1'b0);
    idle(40);
    step(1'b1, 0, 2, 5, 1'b1, 1'b0);
    idle(40);
    // Randomized traffic including invalid channels/addresses, SYNC and RST.
    for (int i = 0; i < 3000; i++) begin
      v  = ($urandom % 4 == 0);
      ch = int'($urandom % 4);
      a  = int'($urandom % 8);
      d  = int'($urandom % 65536);
      if (a == 1 && $urandom % 4 != 0) d = d | 1;
      step(v[0], ch, a, d, ($urandom % 200 == 0), ($urandom % 500 == 0));
    end
    // Reset mid-period.
    wr(0, 1, 1);
    wr(1, 1, 1);
    idle(100);
    step(1'b0, 0, 0, 0, 1'b0, 1'b1);
    idle(5);
    @(negedge CLKOSILLATOR);
    @(negedge CLKOSILLATOR);
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL scoreboard_drain left %0d want 0", exp_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/multichannel_wave_synth.md
# multichannel_wave_synth

Parametrised multi-channel successor to the single-channel waveform generator. Runs CHANNELS independent phase-accumulator oscillators from the ring-oscillator clock. Each channel has selectable waveform (saw, triangle, square with duty, external ROM table, DC), per-channel amplitude scaling and a saturating offset. Channels are configured through a valid/ready register port, and shadowed settings commit glitch-free at phase wrap.

## Interface
- CHANNELS, 2, number of oscillator channels (1..8)
- DATA_W, 8, output sample width
- PHASE_W, 16, phase accumulator width (DATA_W ≤ PHASE_W ≤ 16)
- ADDR_W, 10, ROM table address width (≤ PHASE_W)
- AMP_W, 4, amplitude code width
- CLKOSILLATOR  in  1  sole clock, rising edge
- RST  in  1  synchronous, active-high reset
- SYNC  in  1  one-cycle pulse: zero all accumulators, commit all shadows
- CFG_VALID  in  1  config write request
- CFG_READY  out  1  config port can accept
- CFG_CH  in  3  target channel
- CFG_ADDR  in  3  register select
- CFG_DATA  in  16  write data
- ROM_ADDR  out  CHANNELS*ADDR_W  per-channel table address (channel 0 in LSBs)
- ROM_DATA  in  CHANNELS*DATA_W  per-channel table data, synchronous-read ROM, valid one cycle after ROM_ADDR
- WRAP  out  CHANNELS  one-cycle pulse on accumulator carry
- OUTPUTWAVE  out  CHANNELS*DATA_W  per-channel samples

## Operation
- Write accepted on the rising edge with CFG_VALID && CFG_READY. CFG_CH ≥ CHANNELS or CFG_ADDR ≥ 5: accepted, no effect.
- Register map:
  - 0 FTW = CFG_DATA[PHASE_W-1:0], immediate.
  - 1 CTRL: [0] ENABLE is immediate; [3:1] MODE is shadowed. MODE values: 0 saw, 1 triangle, 2 square, 3 ROM, 4 DC, 5–7 treated as DC.
  - 2 AMP = [AMP_W-1:0], shadowed.
  - 3 OFFSET = [DATA_W-1:0], shadowed.
  - 4 DUTY = [DATA_W-1:0], shadowed.
- Shadow commit: for an enabled channel, commit occurs on the cycle that channel's WRAP pulses, or on SYNC. For a disabled channel, commit is immediate. A second write before commit overwrites the shadow.
- Accumulator: when enabled, acc ← acc + FTW mod 2^PHASE_W. WRAP = carry out. When disabled, acc holds.
- p = acc[PHASE_W-1 -: DATA_W]. Raw waveform by mode:
  - saw = p
  - triangle = p[MSB] ? ~{p[DATA_W-2:0],0} : {p[DATA_W-2:0],0}
  - square = (p < DUTY) ? all-ones : 0
  - ROM = ROM_DATA
  - DC = all-ones
- ROM_ADDR = acc[PHASE_W-1 -: ADDR_W].
- Scaling: scaled = (raw × (AMP+1)) >> AMP_W. AMP all-ones passes raw unchanged. Use a DATA_W+AMP_W+1-bit product.
- Output: OUTPUTWAVE = min(scaled + OFFSET, 2^DATA_W−1), so the sum saturates and never wraps. A disabled channel outputs 0.
- CFG_READY = 0 while RST is high, on the first cycle after RST falls, and on any cycle SYNC is high; otherwise 1.
- SYNC together with a CFG write on the same cycle: SYNC wins and the write is not accepted, because READY is low.

## Timing
- Reset values:
  - acc = 0, FTW = 0, ENABLE = 0, MODE = saw, AMP = all-ones, OFFSET = 0, DUTY = 2^(DATA_W−1).
  - Shadows equal the live values.
  - OUTPUTWAVE = 0, WRAP = 0, ROM_ADDR = 0, CFG_READY = 0.
- Pipeline:
  - Stage 0 is the acc register (cycle t). ROM_ADDR is driven from it in cycle t.
  - Stage 1 (t+1): the internal raw register captures the non-ROM wave, aligned with the external ROM's read register.
  - Stage 2 (t+2): OUTPUTWAVE is registered.
  - Latency from acc value to output is 2 cycles for every mode.
- WRAP is asserted the cycle after the add that carried, aligned with the wrapped acc value. A shadow committed on WRAP affects samples from that acc value onward.
- ENABLE 1→0 freezes acc immediately. OUTPUTWAVE reaches 0 two cycles later.
- SYNC: acc = 0 on the next cycle and WRAP is not pulsed. In-flight pipeline samples complete unchanged.
- RST mid-operation: all state returns to reset values on that edge and the pipeline is flushed. OUTPUTWAVE = 0 from the next cycle.

## Test plan
- Reset: hold RST 3 cycles with random CFG traffic → OUTPUTWAVE = 0, WRAP = 0, CFG_READY low until 2 cycles after RST falls, no register changes.
- Saw ch0: FTW = 0x0100, ENABLE = 1 → ch0 output steps 0,1,2…255 once per cycle starting 2 cycles after acc starts. WRAP[0] pulses every 256 cycles. Ch1 stays 0.
- Shadow amplitude: write AMP = 7 at p = 100 → output keeps full scale until WRAP, then the saw peaks at (255×8)>>4 = 127.
- Saturation and square: MODE = DC, AMP = 3, OFFSET = 200 → output 255 (63+200 saturates). Then MODE = square, AMP = 15, DUTY = 64, FTW = 0x0100 → 64 cycles at 255, 192 cycles at 200.
- ROM mode: ROM model returns ~addr[7:0] one cycle after the address, FTW = 0x0040 → output equals ~ROM_ADDR[7:0] sampled 2 cycles earlier, with no misalignment against a saw-mode channel running in parallel.
- SYNC/RST mid-run: both channels running with different FTW, pulse SYNC → both accs 0 the next cycle and pending shadows commit. Later assert RST mid-period → all outputs 0 the next cycle and ENABLE cleared.
